// File: rtl/torv32_bpred_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : torv32_bpred_if                                                  |
// | Purpose  : Fetch-lookup and execute-resolution signal bundle between the   |
// |            torv32 core (master) and the branch predictor (slave).           |
// | Signals  : f_pc -> f_pred_taken / f_pred_target   (fetch lookup)            |
// |            e_valid, e_pc, e_is_branch, e_is_jump, e_taken, e_target,        |
// |            e_pred_taken, e_pred_target -> e_mispredict / e_redirect_pc      |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
interface torv32_bpred_if;
  logic [31:0] f_pc;
  logic        f_pred_taken;
  logic [31:0] f_pred_target;

  logic        e_valid;
  logic [31:0] e_pc;
  logic        e_is_branch;
  logic        e_is_jump;
  logic        e_taken;
  logic [31:0] e_target;
  logic        e_pred_taken;
  logic [31:0] e_pred_target;
  logic        e_mispredict;
  logic [31:0] e_redirect_pc;

  modport master (
    output f_pc,
    input  f_pred_taken, f_pred_target,
    output e_valid, e_pc, e_is_branch, e_is_jump, e_taken, e_target,
    output e_pred_taken, e_pred_target,
    input  e_mispredict, e_redirect_pc
  );

  modport slave (
    input  f_pc,
    output f_pred_taken, f_pred_target,
    input  e_valid, e_pc, e_is_branch, e_is_jump, e_taken, e_target,
    input  e_pred_taken, e_pred_target,
    output e_mispredict, e_redirect_pc
  );
endinterface
`default_nettype wire

// File: rtl/torv32_bpred.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : torv32_bpred                                                     |
// | Purpose  : Branch predictor for the torv32 5-stage pipeline. Fetch-stage    |
// |            lookup of a direct-mapped BTB and a 2-bit-counter BHT (bimodal   |
// |            or gshare); execute-stage update and mispredict detection.       |
// |            A table-init sweep runs after every reset.                       |
// | Ports    : clk, resetn (sync, active-low)                                   |
// |            bp            : torv32_bpred_if.slave (fetch + execute bundle)   |
// |            busy          : init sweep in progress, core stalls fetch        |
// |            perf_branches : resolved branch/jump count (wraps)               |
// |            perf_mispred  : mispredict count (wraps)                         |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module torv32_bpred #(
  parameter int BHT_BITS = 6,
  parameter int BTB_BITS = 4,
  parameter int GHR_LEN  = 0,
  parameter int TAG_BITS = 30 - BTB_BITS
) (
  input  logic                 clk,
  input  logic                 resetn,
  torv32_bpred_if.slave        bp,
  output logic                 busy,
  output logic [31:0]          perf_branches,
  output logic [31:0]          perf_mispred
);

  localparam int BHT_N      = 1 << BHT_BITS;
  localparam int BTB_N      = 1 << BTB_BITS;
  localparam int SWEEP_BITS = (BHT_BITS > BTB_BITS) ? BHT_BITS : BTB_BITS;
  localparam logic [SWEEP_BITS-1:0] SWEEP_LAST = '1;

  typedef enum logic [0:0] {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  state_t                state;
  logic [SWEEP_BITS-1:0] ptr;
  logic                  run;

  // Tables carry no reset; the init sweep establishes their contents.
  logic [1:0]          bht        [0:BHT_N-1];
  logic                btb_valid  [0:BTB_N-1];
  logic [TAG_BITS-1:0] btb_tag    [0:BTB_N-1];
  logic [31:0]         btb_target [0:BTB_N-1];
  logic                btb_jump   [0:BTB_N-1];

  // Global history, zero-extended to BHT index width (all zeros when bimodal).
  logic [BHT_BITS-1:0] ghr_ext;

  assign run = (state == ST_RUN);

  // ---------------------------------------------------------------------------
  // Global history register
  // ---------------------------------------------------------------------------
  generate
    if (GHR_LEN == 0) begin : g_bimodal
      assign ghr_ext = '0;
    end else begin : g_gshare
      logic [GHR_LEN-1:0] ghr;

      always_ff @(posedge clk) begin
        if (!resetn) begin
          ghr <= '0;
        end else if (run && bp.e_valid && bp.e_is_branch) begin
          // Truncating cast keeps the newest GHR_LEN outcomes.
          ghr <= GHR_LEN'({ghr, bp.e_taken});
        end
      end

      assign ghr_ext = BHT_BITS'(ghr);
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Fetch-stage lookup (zero latency, reads pre-update table state)
  // ---------------------------------------------------------------------------
  logic [BHT_BITS-1:0] f_bidx;
  logic [BTB_BITS-1:0] f_tidx;
  logic [TAG_BITS-1:0] f_tag;
  logic                f_hit;
  logic                f_taken;

  assign f_bidx  = bp.f_pc[BHT_BITS+1:2] ^ ghr_ext;
  assign f_tidx  = bp.f_pc[BTB_BITS+1:2];
  assign f_tag   = bp.f_pc[TAG_BITS+BTB_BITS+1:BTB_BITS+2];
  assign f_hit   = btb_valid[f_tidx] && (btb_tag[f_tidx] == f_tag);
  assign f_taken = run && f_hit && (btb_jump[f_tidx] || bht[f_bidx][1]);

  assign bp.f_pred_taken  = f_taken;
  assign bp.f_pred_target = f_taken ? btb_target[f_tidx] : (bp.f_pc + 32'd4);

  // ---------------------------------------------------------------------------
  // Execute-stage resolution
  // ---------------------------------------------------------------------------
  logic                e_act;
  logic                e_ctrl;
  logic [31:0]         e_nxt;
  logic                e_mp;
  logic [BHT_BITS-1:0] e_bidx;
  logic [BTB_BITS-1:0] e_tidx;
  logic [TAG_BITS-1:0] e_tag;
  logic [1:0]          e_cnt;
  logic [1:0]          e_cnt_nxt;

  assign e_act  = bp.e_is_jump || (bp.e_is_branch && bp.e_taken);
  assign e_ctrl = bp.e_valid && (bp.e_is_branch || bp.e_is_jump);
  assign e_nxt  = e_act ? bp.e_target : (bp.e_pc + 32'd4);
  assign e_mp   = run && e_ctrl &&
                  ((e_act != bp.e_pred_taken) ||
                   (e_act && (bp.e_target != bp.e_pred_target)));

  assign bp.e_mispredict  = e_mp;
  assign bp.e_redirect_pc = e_nxt;

  assign e_bidx = bp.e_pc[BHT_BITS+1:2] ^ ghr_ext;
  assign e_tidx = bp.e_pc[BTB_BITS+1:2];
  assign e_tag  = bp.e_pc[TAG_BITS+BTB_BITS+1:BTB_BITS+2];
  assign e_cnt  = bht[e_bidx];

  // Saturating 2-bit counter step.
  always_comb begin
    e_cnt_nxt = e_cnt;
    if (bp.e_taken) begin
      if (e_cnt != 2'b11) e_cnt_nxt = e_cnt + 2'b01;
    end else begin
      if (e_cnt != 2'b00) e_cnt_nxt = e_cnt - 2'b01;
    end
  end

  // ---------------------------------------------------------------------------
  // Table writes: sweep during INIT, training during RUN
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (resetn) begin
      if (!run) begin
        // Smaller table index wraps; rewriting an entry is harmless.
        bht[ptr[BHT_BITS-1:0]]       <= 2'b01;
        btb_valid[ptr[BTB_BITS-1:0]] <= 1'b0;
      end else if (bp.e_valid) begin
        if (bp.e_is_branch) begin
          bht[e_bidx] <= e_cnt_nxt;
        end
        if (e_act) begin
          btb_valid[e_tidx]  <= 1'b1;
          btb_tag[e_tidx]    <= e_tag;
          btb_target[e_tidx] <= bp.e_target;
          btb_jump[e_tidx]   <= bp.e_is_jump;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM, busy flag and performance counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state         <= ST_INIT;
      ptr           <= '0;
      busy          <= 1'b1;
      perf_branches <= '0;
      perf_mispred  <= '0;
    end else if (state == ST_INIT) begin
      ptr <= ptr + 1'b1;
      if (ptr == SWEEP_LAST) begin
        state <= ST_RUN;
        busy  <= 1'b0;
      end
    end else begin
      if (e_ctrl) perf_branches <= perf_branches + 32'd1;
      if (e_mp)   perf_mispred  <= perf_mispred + 32'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_torv32_bpred.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_torv32_bpred                                                  |
// | Purpose  : Directed self-checking bench for torv32_bpred. A bimodal build   |
// |            and a GHR_LEN=2 gshare build receive identical stimulus.         |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_torv32_bpred;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  torv32_bpred_if bif ();
  torv32_bpred_if gif ();

  logic        b_busy, g_busy;
  logic [31:0] b_pb, b_pm, g_pb, g_pm;

  torv32_bpred u_bim (
    .clk           (clk),
    .resetn        (resetn),
    .bp            (bif.slave),
    .busy          (b_busy),
    .perf_branches (b_pb),
    .perf_mispred  (b_pm)
  );

  torv32_bpred #(.GHR_LEN(2)) u_gsh (
    .clk           (clk),
    .resetn        (resetn),
    .bp            (gif.slave),
    .busy          (g_busy),
    .perf_branches (g_pb),
    .perf_mispred  (g_pm)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic idle_e();
    bif.e_valid = 1'b0; bif.e_pc = '0; bif.e_is_branch = 1'b0; bif.e_is_jump = 1'b0;
    bif.e_taken = 1'b0; bif.e_target = '0; bif.e_pred_taken = 1'b0; bif.e_pred_target = '0;
    gif.e_valid = 1'b0; gif.e_pc = '0; gif.e_is_branch = 1'b0; gif.e_is_jump = 1'b0;
    gif.e_taken = 1'b0; gif.e_target = '0; gif.e_pred_taken = 1'b0; gif.e_pred_target = '0;
  endtask

  // Look up pc, carry each build's own prediction into E, resolve, clock once.
  task automatic resolve(input logic [31:0] pc, input logic isb, input logic isj,
                         input logic tk, input logic [31:0] tgt,
                         output logic b_mp, output logic [31:0] b_rd, output logic g_mp);
    bif.f_pc = pc; gif.f_pc = pc;
    #1;
    bif.e_pred_taken = bif.f_pred_taken; bif.e_pred_target = bif.f_pred_target;
    gif.e_pred_taken = gif.f_pred_taken; gif.e_pred_target = gif.f_pred_target;
    bif.e_valid = 1'b1; bif.e_pc = pc; bif.e_is_branch = isb; bif.e_is_jump = isj;
    bif.e_taken = tk; bif.e_target = tgt;
    gif.e_valid = 1'b1; gif.e_pc = pc; gif.e_is_branch = isb; gif.e_is_jump = isj;
    gif.e_taken = tk; gif.e_target = tgt;
    #1;
    b_mp = bif.e_mispredict; b_rd = bif.e_redirect_pc; g_mp = gif.e_mispredict;
    @(posedge clk); #1;
    idle_e();
  endtask

  task automatic lookup(input logic [31:0] pc, output logic tk, output logic [31:0] tg);
    bif.f_pc = pc; gif.f_pc = pc;
    #1;
    tk = bif.f_pred_taken; tg = bif.f_pred_target;
  endtask

  // Counts samples with busy high, starting at the release of reset.
  task automatic wait_sweep(output int n);
    n = 0;
    while (b_busy && n < 300) begin
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset(output int n);
    resetn = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    resetn = 1'b1;
    wait_sweep(n);
  endtask

  task automatic test_reset();
    int n, bad;
    logic tk; logic [31:0] tg;
    resetn = 1'b0; idle_e(); bif.f_pc = 32'h100; gif.f_pc = 32'h100;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (b_busy !== 1'b1 || g_busy !== 1'b1) begin
      n_fail++; $display("FAIL reset_busy: got %b/%b expected 1/1", b_busy, g_busy);
    end
    n_checks++;
    if (b_pb !== 32'd0 || b_pm !== 32'd0) begin
      n_fail++; $display("FAIL reset_perf: got %h/%h expected 0/0", b_pb, b_pm);
    end
    n_checks++;
    if (bif.f_pred_taken !== 1'b0 || bif.e_mispredict !== 1'b0) begin
      n_fail++; $display("FAIL reset_pred: got taken=%b mp=%b expected 0/0",
                         bif.f_pred_taken, bif.e_mispredict);
    end
    // Release and sweep, with a would-be mispredicting jump on E throughout.
    resetn = 1'b1;
    n = 0; bad = 0;
    while (b_busy && n < 300) begin
      n++;
      bif.f_pc = $urandom; gif.f_pc = bif.f_pc;
      bif.e_valid = 1'b1; bif.e_pc = 32'h700; bif.e_is_jump = 1'b1; bif.e_target = 32'h800;
      #1;
      if (bif.f_pred_taken !== 1'b0 || bif.e_mispredict !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    idle_e();
    n_checks++;
    if (n !== 64) begin
      n_fail++; $display("FAIL sweep_len: got %0d busy cycles expected 64", n);
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++; $display("FAIL sweep_quiet: got %0d active cycles expected 0", bad);
    end
    n_checks++;
    if (b_pb !== 32'd0 || b_pm !== 32'd0) begin
      n_fail++; $display("FAIL sweep_perf: got %h/%h expected 0/0", b_pb, b_pm);
    end
    lookup(32'h700, tk, tg);
    n_checks++;
    if (tk !== 1'b0 || tg !== 32'h704) begin
      n_fail++; $display("FAIL sweep_noupd: got %b/%h expected 0/00000704", tk, tg);
    end
  endtask

  task automatic test_jal();
    logic mp, gmp, tk; logic [31:0] rd, tg;
    resolve(32'h100, 1'b0, 1'b1, 1'b0, 32'h200, mp, rd, gmp);
    n_checks++;
    if (mp !== 1'b1 || rd !== 32'h200) begin
      n_fail++; $display("FAIL jal_first: got mp=%b rd=%h expected 1/00000200", mp, rd);
    end
    lookup(32'h100, tk, tg);
    n_checks++;
    if (tk !== 1'b1 || tg !== 32'h200) begin
      n_fail++; $display("FAIL jal_lookup: got %b/%h expected 1/00000200", tk, tg);
    end
    resolve(32'h100, 1'b0, 1'b1, 1'b0, 32'h200, mp, rd, gmp);
    n_checks++;
    if (mp !== 1'b0 || rd !== 32'h200) begin
      n_fail++; $display("FAIL jal_second: got mp=%b rd=%h expected 0/00000200", mp, rd);
    end
    n_checks++;
    if (b_pb !== 32'd2 || b_pm !== 32'd1) begin
      n_fail++; $display("FAIL jal_perf: got %0d/%0d expected 2/1", b_pb, b_pm);
    end
  endtask

  task automatic test_branch();
    logic mp, gmp, tk; logic [31:0] rd, tg;
    logic exp_mp [3] = '{1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 3; i++) begin
      resolve(32'h40, 1'b1, 1'b0, 1'b1, 32'h400, mp, rd, gmp);
      n_checks++;
      if (mp !== exp_mp[i] || rd !== 32'h400) begin
        n_fail++; $display("FAIL br_taken%0d: got mp=%b rd=%h expected %b/00000400",
                           i, mp, rd, exp_mp[i]);
      end
    end
    resolve(32'h40, 1'b1, 1'b0, 1'b0, 32'h400, mp, rd, gmp);
    n_checks++;
    if (mp !== 1'b1 || rd !== 32'h44) begin
      n_fail++; $display("FAIL br_nt1: got mp=%b rd=%h expected 1/00000044", mp, rd);
    end
    lookup(32'h40, tk, tg);
    n_checks++;
    if (tk !== 1'b1 || tg !== 32'h400) begin
      n_fail++; $display("FAIL br_still_taken: got %b/%h expected 1/00000400", tk, tg);
    end
    // Counter 10 -> 01: mispredict again, then predicts not-taken.
    resolve(32'h40, 1'b1, 1'b0, 1'b0, 32'h400, mp, rd, gmp);
    n_checks++;
    if (mp !== 1'b1 || rd !== 32'h44) begin
      n_fail++; $display("FAIL br_nt2: got mp=%b rd=%h expected 1/00000044", mp, rd);
    end
    lookup(32'h40, tk, tg);
    n_checks++;
    if (tk !== 1'b0 || tg !== 32'h44) begin
      n_fail++; $display("FAIL br_now_nt: got %b/%h expected 0/00000044", tk, tg);
    end
    n_checks++;
    if (b_pb !== 32'd7 || b_pm !== 32'd4) begin
      n_fail++; $display("FAIL br_perf: got %0d/%0d expected 7/4", b_pb, b_pm);
    end
  endtask

  task automatic test_gshare();
    int n, b_cnt, g_cnt;
    logic mp, gmp; logic [31:0] rd;
    do_reset(n);
    n_checks++;
    if (n !== 64 || g_busy !== 1'b0) begin
      n_fail++; $display("FAIL gs_sweep: got %0d busy cycles g_busy=%b expected 64/0", n, g_busy);
    end
    for (int i = 0; i < 4; i++)
      resolve(32'h80, 1'b1, 1'b0, ((i % 2) == 0), 32'h300, mp, rd, gmp);
    b_cnt = 0; g_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      resolve(32'h80, 1'b1, 1'b0, ((i % 2) == 0), 32'h300, mp, rd, gmp);
      if (mp)  b_cnt++;
      if (gmp) g_cnt++;
    end
    n_checks++;
    if (g_cnt !== 0) begin
      n_fail++; $display("FAIL gs_steady: got %0d gshare mispredicts expected 0", g_cnt);
    end
    n_checks++;
    if (b_cnt !== 20) begin
      n_fail++; $display("FAIL bim_alt: got %0d bimodal mispredicts expected 20", b_cnt);
    end
    n_checks++;
    if (g_pb !== 32'd24 || g_pm !== 32'd2) begin
      n_fail++; $display("FAIL gs_perf: got %0d/%0d expected 24/2", g_pb, g_pm);
    end
    n_checks++;
    if (b_pb !== 32'd24 || b_pm !== 32'd24) begin
      n_fail++; $display("FAIL bim_perf: got %0d/%0d expected 24/24", b_pb, b_pm);
    end
  endtask

  task automatic test_alias();
    logic mp, gmp, tk; logic [31:0] rd, tg;
    resolve(32'h10, 1'b0, 1'b1, 1'b0, 32'h500, mp, rd, gmp);
    lookup(32'h10, tk, tg);
    n_checks++;
    if (tk !== 1'b1 || tg !== 32'h500) begin
      n_fail++; $display("FAIL alias_first: got %b/%h expected 1/00000500", tk, tg);
    end
    resolve(32'h50, 1'b0, 1'b1, 1'b0, 32'h600, mp, rd, gmp);
    n_checks++;
    if (mp !== 1'b1 || rd !== 32'h600) begin
      n_fail++; $display("FAIL alias_miss: got mp=%b rd=%h expected 1/00000600", mp, rd);
    end
    lookup(32'h10, tk, tg);
    n_checks++;
    if (tk !== 1'b0 || tg !== 32'h14) begin
      n_fail++; $display("FAIL alias_evicted: got %b/%h expected 0/00000014", tk, tg);
    end
    lookup(32'h50, tk, tg);
    n_checks++;
    if (tk !== 1'b1 || tg !== 32'h600) begin
      n_fail++; $display("FAIL alias_second: got %b/%h expected 1/00000600", tk, tg);
    end
  endtask

  task automatic test_midreset();
    int n;
    logic mp, gmp, tk; logic [31:0] rd, tg;
    logic [31:0] pcs [4] = '{32'h100, 32'h10, 32'h50, 32'h80};
    resolve(32'h100, 1'b0, 1'b1, 1'b0, 32'h200, mp, rd, gmp);
    lookup(32'h100, tk, tg);
    n_checks++;
    if (tk !== 1'b1 || tg !== 32'h200) begin
      n_fail++; $display("FAIL mr_trained: got %b/%h expected 1/00000200", tk, tg);
    end
    resetn = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (b_busy !== 1'b1 || b_pb !== 32'd0 || b_pm !== 32'd0 || bif.f_pred_taken !== 1'b0) begin
      n_fail++; $display("FAIL mr_reset: got busy=%b pb=%0d pm=%0d tk=%b expected 1/0/0/0",
                         b_busy, b_pb, b_pm, bif.f_pred_taken);
    end
    @(posedge clk); #1;
    resetn = 1'b1;
    wait_sweep(n);
    n_checks++;
    if (n !== 64) begin
      n_fail++; $display("FAIL mr_sweep: got %0d busy cycles expected 64", n);
    end
    foreach (pcs[i]) begin
      lookup(pcs[i], tk, tg);
      n_checks++;
      if (tk !== 1'b0 || tg !== pcs[i] + 32'd4) begin
        n_fail++; $display("FAIL mr_cleared %h: got %b/%h expected 0/%h",
                           pcs[i], tk, tg, pcs[i] + 32'd4);
      end
    end
  endtask

  initial begin
    bif.f_pc = '0; gif.f_pc = '0;
    idle_e();
    test_reset();
    test_jal();
    test_branch();
    test_gshare();
    test_alias();
    test_midreset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
